muldiv_sequencer: RTL and testbench

Multi-cycle HI/LO multiply/divide sequencer for the 5-stage MIPS pipeline. It accepts mult/multu/div/divu from the EX stage and runs an iterative shift-add multiplier or restoring divider. It owns the HI and LO registers and raises a stall request to the hazard unit whenever an EX-stage instruction needs the unit or HI/LO while an operation is in flight.

---
 rtl/muldiv_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Multi-cycle HI/LO unit for the 5-stage MIPS pipeline. It accepts
//   mult/multu/div/divu from EX and runs an iterative shift-add multiplier or
//   a restoring divider, one result bit per cycle. It owns the architectural
//   HI/LO registers. While an operation is in flight, it asks the hazard unit
//   to stall any EX instruction that needs the unit or HI/LO.
//
// Optional feature (compile-time macro MD_EARLY_OUT_EN):
//   defined     - a multiply leaves RUN once the remaining multiplier bits are
//                 all zero (after at least one RUN cycle). A divide by zero
//                 goes straight from IDLE to FIX.
//   not defined - every operation is busy for exactly DATA_W+1 cycles.
//
// Ports:
//   clk             pipeline clock, all state changes on the rising edge
//   rst             synchronous active-high reset; aborts any operation
//   startE          mult/multu/div/divu valid in EX
//   opE[1:0]        00 mult, 01 multu, 10 div, 11 divu
//   srcAE, srcBE    rs / rt operands; srcAE is also the mthi/mtlo data
//   mfhiE, mfloE    mfhi / mflo in EX
//   mthiE, mtloE    mthi / mtlo in EX
//   stallMD         stall request to the hazard unit
//   busy            operation in flight
//   done            one-cycle pulse in the cycle HI/LO are written
//   hi, lo          architectural HI/LO
//   hiloE           HI or LO for mfhi/mflo, zero otherwise
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              startE,
  input  logic [1:0]        opE,
  input  logic [DATA_W-1:0] srcAE,
  input  logic [DATA_W-1:0] srcBE,
  input  logic              mfhiE,
  input  logic              mfloE,
  input  logic              mthiE,
  input  logic              mtloE,
  output logic              stallMD,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hiloE
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                neg_res_q, neg_res_d;
  logic                neg_rem_q, neg_rem_d;
  logic                div_zero_q, div_zero_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [DATA_W-1:0]   orig_a_q, orig_a_d;
  logic [DATA_W-1:0]   hi_q, hi_d;
  logic [DATA_W-1:0]   lo_q, lo_d;

  logic                signed_op;
  logic [DATA_W-1:0]   abs_a, abs_b;
  logic [DATA_W:0]     shifted_rem, trial;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;

  // Status outputs are pure decodes of the state. The stall is combinational
  // so that an EX instruction which needs the unit is held in the very
  // cycle it shows up while an operation is in flight.
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_FIX);
    stallMD = busy && (startE | mfhiE | mfloE | mthiE | mtloE);
    hi      = hi_q;
    lo      = lo_q;
    hiloE   = '0;
    if (mfhiE) begin
      hiloE = hi_q;
    end else if (mfloE) begin
      hiloE = lo_q;
    end
  end

  // Next-state and datapath logic for the IDLE/RUN/FIX sequencer.
  // The iterations work on magnitudes only. The signs are recorded at
  // start and applied once, in FIX, so RUN is the same for signed and
  // unsigned ops. The divider keeps {remainder, quotient} in acc: the
  // remainder is in the upper half and the dividend shifts out of the
  // lower half as the quotient bits shift in.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    orig_a_d   = orig_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    signed_op = ~opE[0];
    abs_a     = (signed_op && srcAE[DATA_W-1]) ? (~srcAE + 1'b1) : srcAE;
    abs_b     = (signed_op && srcBE[DATA_W-1]) ? (~srcBE + 1'b1) : srcBE;

    // The remainder is below the divisor, so the shifted remainder is below
    // twice the divisor. A (DATA_W+1)-bit trial difference therefore has
    // its top bit set exactly when the subtraction underflows.
    shifted_rem = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    trial       = shifted_rem - {1'b0, opb_q};

    prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[DATA_W-1:0] + 1'b1) : acc_q[DATA_W-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[2*DATA_W-1:DATA_W] + 1'b1)
                         : acc_q[2*DATA_W-1:DATA_W];

    case (state_q)
      S_IDLE: begin
        if (startE) begin
          is_div_d   = opE[1];
          neg_res_d  = signed_op & (srcAE[DATA_W-1] ^ srcBE[DATA_W-1]);
          neg_rem_d  = signed_op & srcAE[DATA_W-1];
          div_zero_d = (srcBE == '0);
          orig_a_d   = srcAE;
          cnt_d      = CNT_W'(DATA_W);
          opb_d      = abs_b;
          state_d    = S_RUN;
          if (opE[1]) begin
            acc_d   = {{DATA_W{1'b0}}, abs_a};
            mcand_d = '0;
`ifdef MD_EARLY_OUT_EN
            if (srcBE == '0) begin
              state_d = S_FIX;
            end
`endif
          end else begin
            acc_d   = '0;
            mcand_d = {{DATA_W{1'b0}}, abs_a};
          end
        end else begin
          if (mthiE) begin
            hi_d = srcAE;
          end
          if (mtloE) begin
            lo_d = srcAE;
          end
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (is_div_q) begin
          if (!trial[DATA_W]) begin
            acc_d = {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
          end else begin
            acc_d = {shifted_rem[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
          end
        end else begin
          if (opb_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d = {mcand_q[2*DATA_W-2:0], 1'b0};
          opb_d   = {1'b0, opb_q[DATA_W-1:1]};
        end
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
`ifdef MD_EARLY_OUT_EN
        if (!is_div_q && (opb_d == '0)) begin
          state_d = S_FIX;
        end
`endif
      end

      S_FIX: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (!is_div_q) begin
          hi_d = prod_fix[2*DATA_W-1:DATA_W];
          lo_d = prod_fix[DATA_W-1:0];
        end else if (div_zero_q) begin
          hi_d = orig_a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register. Reset also clears HI/LO, so an operation that is
  // aborted in RUN or FIX never leaves a partial result behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      orig_a_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      orig_a_q   <= orig_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Self-checking bench for muldiv_sequencer. A behavioural model computes
// each result with plain integer arithmetic and tracks only how many busy
// cycles remain. A compare process checks every DUT output against that
// model on every falling edge. Directed cases pin the model with literal
// results and timings, and a randomized instruction stream follows them.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

   localparam int W = 32;

`ifdef MD_EARLY_OUT_EN
   localparam int BUSY_MULT_NEG = 4;
   localparam int BUSY_MULTU_2  = 3;
   localparam int BUSY_DIVZERO  = 1;
   localparam int BUSY_MULT_3X4 = 4;
`else
   localparam int BUSY_MULT_NEG = 33;
   localparam int BUSY_MULTU_2  = 33;
   localparam int BUSY_DIVZERO  = 33;
   localparam int BUSY_MULT_3X4 = 33;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          startE;
   logic [1:0]    opE;
   logic [W-1:0]  srcAE, srcBE;
   logic          mfhiE, mfloE, mthiE, mtloE;
   logic          stallMD, busy, done;
   logic [W-1:0]  hi, lo, hiloE;

   int            checks = 0;
   int            errors = 0;

   int            mRem = 0;
   logic [W-1:0]  mHi = '0, mLo = '0, mPendHi = '0, mPendLo = '0;
   bit            chkEn = 1'b0;

   muldiv_sequencer #(.DATA_W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .startE  (startE),
      .opE     (opE),
      .srcAE   (srcAE),
      .srcBE   (srcBE),
      .mfhiE   (mfhiE),
      .mfloE   (mfloE),
      .mthiE   (mthiE),
      .mtloE   (mtloE),
      .stallMD (stallMD),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo),
      .hiloE   (hiloE)
   );

   // Free-running pipeline clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Single place where a comparison is counted and reported.
   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t",
                  name, actual, expected, $time);
      end
   endtask

   // Architectural result of one operation as {HI, LO}, from integer arithmetic.
   function automatic logic [2*W-1:0] refResult(input logic [1:0] op,
                                                input logic [W-1:0] a,
                                                input logic [W-1:0] b);
      logic [2*W-1:0] p;
      longint         pl;
      int             sa, sb, q, r;
      sa = a;
      sb = b;
      p  = '0;
      case (op)
         2'b00: begin
            pl = longint'(sa) * longint'(sb);
            p  = pl;
         end
         2'b01: p = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0)                                  p = {a, 32'hFFFF_FFFF};
            else if (a == 32'h8000_0000 && b == '1)      p = {32'h0, 32'h8000_0000};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r, q};
            end
         end
         default: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else        p = {a % b, a / b};
         end
      endcase
      return p;
   endfunction

   // Number of busy cycles for an operation (RUN cycles plus FIX).
   function automatic int refLatency(input logic [1:0] op, input logic [W-1:0] b);
`ifdef MD_EARLY_OUT_EN
      logic [W-1:0] mag;
      int           run;
      if (op[1]) return (b == 0) ? 1 : W + 1;
      mag = (op == 2'b00 && b[W-1]) ? -b : b;
      run = 1;
      while (run < W && (mag >> run) != 0) run++;
      return run + 1;
`else
      if (op[1] && b == 0) return W + 1;
      return W + 1;
`endif
   endfunction

   // Behavioural model. It advances on each rising edge from the inputs the
   // bench presented during the cycle that just ended.
   initial begin
      logic [2*W-1:0] res;
      forever begin
         @(posedge clk);
         if (rst) begin
            mRem  = 0;
            mHi   = '0;
            mLo   = '0;
            chkEn = 1'b1;
         end else if (mRem > 0) begin
            mRem--;
            if (mRem == 0) begin
               mHi = mPendHi;
               mLo = mPendLo;
            end
         end else if (startE) begin
            res     = refResult(opE, srcAE, srcBE);
            mPendHi = res[2*W-1:W];
            mPendLo = res[W-1:0];
            mRem    = refLatency(opE, srcBE);
         end else begin
            if (mthiE) mHi = srcAE;
            if (mtloE) mLo = srcAE;
         end
      end
   end

   // Compare process: every falling edge, every output against the model.
   initial begin
      logic          expBusy, expDone, expStall;
      logic [W-1:0]  expHilo;
      forever begin
         @(negedge clk);
         if (chkEn) begin
            expBusy  = (mRem > 0);
            expDone  = (mRem == 1);
            expStall = expBusy && (startE | mfhiE | mfloE | mthiE | mtloE);
            expHilo  = mfhiE ? mHi : (mfloE ? mLo : '0);
            checkOutput("busy",    W'(busy),    W'(expBusy));
            checkOutput("done",    W'(done),    W'(expDone));
            checkOutput("stallMD", W'(stallMD), W'(expStall));
            checkOutput("hi",      hi,          mHi);
            checkOutput("lo",      lo,          mLo);
            checkOutput("hiloE",   hiloE,       expHilo);
         end
      end
   end

   // Stops a hung run on its own.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic clearInputs();
      startE = 1'b0; opE = 2'b00; srcAE = '0; srcBE = '0;
      mfhiE = 1'b0; mfloE = 1'b0; mthiE = 1'b0; mtloE = 1'b0;
   endtask

   // Presents one EX instruction and holds it while the pipeline would be
   // stalled. kind: 0 start, 1 mfhi, 2 mflo, 3 mthi, 4 mtlo, 5 bubble.
   // The task is entered and left 1 time unit after a rising edge.
   task automatic applyStimulus(input int kind, input logic [1:0] op,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      startE = (kind == 0); opE = op; srcAE = a; srcBE = b;
      mfhiE = (kind == 1); mfloE = (kind == 2);
      mthiE = (kind == 3); mtloE = (kind == 4);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!(mRem > 0 && kind != 5)) begin
            @(posedge clk);
            #1;
            clearInputs();
            return;
         end
      end
      checks++;
      errors++;
      $display("[TB] FAIL hold-timeout: instruction kind %0d still stalled after 200 cycles", kind);
      clearInputs();
   endtask

   // Issues one operation, measures busy length and done position (offset 1
   // is the cycle after acceptance), then checks HI/LO against literals.
   task automatic runOp(input string name, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expHi, input logic [W-1:0] expLo,
                        input int expBusy);
      int busyCycles, doneAt;
      busyCycles = 0;
      doneAt     = 0;
      applyStimulus(0, op, a, b);
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) doneAt = k;
         if (!busy) break;
         busyCycles++;
      end
      checkOutput({name, "-busycycles"}, W'(busyCycles), W'(expBusy));
      checkOutput({name, "-doneat"},     W'(doneAt),     W'(expBusy));
      checkOutput({name, "-hi"},         hi,             expHi);
      checkOutput({name, "-lo"},         lo,             expLo);
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] randOperand();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return W'($urandom_range(0, 20));
         5:       return -W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int stallCnt, donePulses;
      clearInputs();
      rst = 1'b1;

      // Reset state.
      @(posedge clk);
      @(negedge clk);
      checkOutput("reset-busy",  W'(busy),    '0);
      checkOutput("reset-done",  W'(done),    '0);
      checkOutput("reset-stall", W'(stallMD), '0);
      checkOutput("reset-hi",    hi,          '0);
      checkOutput("reset-lo",    lo,          '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] directed operations");
      runOp("mult-neg",  2'b00, 32'hFFFF_FFFD, 32'd5,
            32'hFFFF_FFFF, 32'hFFFF_FFF1, BUSY_MULT_NEG);
      runOp("multu-max", 2'b01, 32'hFFFF_FFFF, 32'd2,
            32'h0000_0001, 32'hFFFF_FFFE, BUSY_MULTU_2);
      runOp("div-neg",   2'b10, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
      runOp("divu",      2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 33);
      runOp("div-ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0, 32'h8000_0000, 33);
      runOp("divu-zero", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, BUSY_DIVZERO);
      runOp("div-zero",  2'b10, 32'hFFFF_FFF0, 32'd0,
            32'hFFFF_FFF0, 32'hFFFF_FFFF, BUSY_DIVZERO);

      // mflo right behind a mult is held, then reads the new LO on release.
      $display("[TB] mflo behind mult");
      applyStimulus(0, 2'b00, 32'd3, 32'd4);
      mfloE    = 1'b1;
      stallCnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (!stallMD) break;
         stallCnt++;
      end
      checkOutput("mflo-stallcycles", W'(stallCnt), W'(BUSY_MULT_3X4));
      checkOutput("mflo-release",     hiloE,        32'd12);
      @(posedge clk);
      #1;
      clearInputs();

      // mthi while idle updates HI at the edge, with no stall.
      $display("[TB] mthi while idle");
      mthiE = 1'b1;
      srcAE = 32'h1234;
      @(negedge clk);
      checkOutput("mthi-nostall", W'(stallMD), '0);
      @(posedge clk);
      #1;
      clearInputs();
      @(negedge clk);
      checkOutput("mthi-hi", hi, 32'h1234);
      @(posedge clk);
      #1;

      // Reset during RUN cycle 10 aborts the operation cleanly.
      $display("[TB] reset during RUN");
      applyStimulus(0, 2'b01, 32'h0001_0001, 32'hFFFF_FFFF);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort-busy", W'(busy), '0);
      checkOutput("abort-hi",   hi,       '0);
      checkOutput("abort-lo",   lo,       '0);
      donePulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) donePulses++;
      end
      checkOutput("abort-nodone", W'(donePulses), '0);
      @(posedge clk);
      #1;

      // Randomized instruction stream, including back-to-back starts and
      // HI/LO accesses while an operation is in flight.
      $display("[TB] random stream");
      for (int n = 0; n < 400; n++) begin
         applyStimulus($urandom_range(0, 5), 2'($urandom_range(0, 3)),
                       randOperand(), randOperand());
      end
      for (int k = 0; k < 100 && mRem > 0; k++) begin
         @(posedge clk);
      end
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
